// File: rtl/mux_nto1_rr_pkg.sv
// Shared sCPU definitions for the N:1 registered mux.
// Provides the select-mode encodings.
package mux_nto1_rr_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

endpackage

// File: rtl/mux_nto1_rr_pick.sv
// rr_pick: combinational round-robin picker, search starts at ptr+1.
// Ports: req (N requests), ptr (last grant) in; grant_valid, grant_idx out.
module rr_pick #(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic          grant_valid,
  output logic [SW-1:0] grant_idx
);

  logic [2*N-1:0] w_dbl;
  logic [SW:0]    w_base;
  logic [N-1:0]   w_rot;
  logic [SW-1:0]  w_pos;
  logic [SW:0]    w_sum;

  // Rotate so bit 0 of w_rot is channel ptr+1.
  assign w_dbl  = {req, req};
  assign w_base = {1'b0, ptr} + 1'b1;
  assign w_rot  = w_dbl[w_base +: N];

  always_comb begin
    w_pos = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (w_rot[j]) w_pos = SW'(j);
    end
  end

  // Un-rotate back to an absolute channel index.
  always_comb begin
    w_sum = w_base + {1'b0, w_pos};
    if (w_sum >= (SW+1)'(N)) w_sum = w_sum - (SW+1)'(N);
  end

  assign grant_valid = |req;
  assign grant_idx   = w_sum[SW-1:0];

endmodule

// File: rtl/mux_nto1_rr.sv
// Registered N:1 mux with valid/ready per channel, sel or round-robin.
// Ports: in_data/in_valid/in_ready, mode/sel, out_data/out_src/out_valid/out_ready.
module mux_nto1_rr
  import mux_nto1_rr_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int NUM_IN = 4,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [SEL_W-1:0] r_ptr;
  logic [WIDTH-1:0] r_data;
  logic [SEL_W-1:0] r_src;
  logic             r_valid;

  logic             w_load_en;
  logic             w_rr_gv;
  logic [SEL_W-1:0] w_rr_gi;
  logic             w_sel_gv;
  logic             w_gv;
  logic [SEL_W-1:0] w_gi;
  logic [WIDTH-1:0] w_gdata;

  rr_pick #(
    .N  (NUM_IN),
    .SW (SEL_W)
  ) u_pick (
    .req         (in_valid),
    .ptr         (r_ptr),
    .grant_valid (w_rr_gv),
    .grant_idx   (w_rr_gi)
  );

  assign w_load_en = !r_valid || out_ready;

  // Out-of-range sel never grants (only possible for non power-of-2 NUM_IN).
  always_comb begin
    w_sel_gv = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel == SEL_W'(i) && in_valid[i]) w_sel_gv = 1'b1;
    end
  end

  assign w_gv = (mode == MODE_RR) ? w_rr_gv : w_sel_gv;
  assign w_gi = (mode == MODE_RR) ? w_rr_gi : sel;

  always_comb begin
    w_gdata  = '0;
    in_ready = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (w_gi == SEL_W'(i)) begin
        w_gdata     = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = !rst && w_load_en && w_gv;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_src   <= '0;
      r_ptr   <= SEL_W'(NUM_IN - 1);
    end else if (w_load_en) begin
      if (w_gv) begin
        r_valid <= 1'b1;
        r_data  <= w_gdata;
        r_src   <= w_gi;
        if (mode == MODE_RR) r_ptr <= w_gi;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_data;
  assign out_src   = r_src;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Self-checking bench for mux_nto1_rr: directed steps then random traffic.
// Reference model tracks output register and last RR grant arithmetically.
module tb_mux_nto1_rr;

  localparam int W  = 4;
  localparam int N  = 4;
  localparam int SW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_ready;
  logic          mode;
  logic [SW-1:0] sel;
  logic [W-1:0]  out_data;
  logic [SW-1:0] out_src;
  logic          out_valid;
  logic          out_ready;

  int checks = 0;
  int errors = 0;

  int m_ptr;
  int m_valid;
  int m_data;
  int m_src;

  mux_nto1_rr #(.WIDTH(W), .NUM_IN(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int chan(input int c);
    logic [N*W-1:0] d;
    d = in_data;
    return int'(d[c*W +: W]);
  endfunction

  // Grant rule stated directly: sel if valid, or first valid after ptr.
  task automatic model_grant(output bit gv, output int gi);
    gv = 0;
    gi = 0;
    if (mode == 1'b0) begin
      if (int'(sel) < N && in_valid[sel]) begin
        gv = 1;
        gi = int'(sel);
      end
    end else begin
      for (int k = 1; k <= N && !gv; k++) begin
        if (in_valid[(m_ptr + k) % N]) begin
          gv = 1;
          gi = (m_ptr + k) % N;
        end
      end
    end
  endtask

  task automatic step();
    bit gv;
    int gi;
    bit le;
    logic [N-1:0] er;
    @(negedge clk);
    model_grant(gv, gi);
    le = (m_valid == 0) || out_ready;
    er = '0;
    if (!rst && le && gv) er[gi] = 1'b1;
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("onehot", 32'($onehot0(in_ready)), 32'd1);
    @(posedge clk);
    if (rst) begin
      m_valid = 0;
      m_data  = 0;
      m_src   = 0;
      m_ptr   = N - 1;
    end else if (le) begin
      if (gv) begin
        m_valid = 1;
        m_data  = chan(gi);
        m_src   = gi;
        if (mode) m_ptr = gi;
      end else begin
        m_valid = 0;
      end
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_src", 32'(out_src), 32'(m_src));
  endtask

  task automatic set_data(input int d0, input int d1,
                          input int d2, input int d3);
    in_data = {W'(d3), W'(d2), W'(d1), W'(d0)};
  endtask

  int exp_src[5];
  int exp_dat[5];

  initial begin
    m_ptr = N - 1;
    m_valid = 0;
    m_data = 0;
    m_src = 0;
    rst = 1'b1;
    mode = 1'b1;
    sel = '0;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    set_data(1, 2, 3, 4);

    // Reset with every channel requesting.
    step();
    step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_src", 32'(out_src), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);

    // Round-robin fairness, first grant channel 0.
    rst = 1'b0;
    exp_src = '{0, 1, 2, 3, 0};
    exp_dat = '{1, 2, 3, 4, 1};
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_src", 32'(out_src), 32'(exp_src[i]));
      chk("rr_data", 32'(out_data), 32'(exp_dat[i]));
    end

    // Channel 1 dropped: 2, 3, 0.
    in_valid = 4'b1101;
    exp_src[0] = 2;
    exp_src[1] = 3;
    exp_src[2] = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rr_skip", 32'(out_src), 32'(exp_src[i]));
    end

    // Software select.
    mode = 1'b0;
    sel = 2'd2;
    set_data(1, 2, 'hA, 4);
    in_valid = 4'b0100;
    @(negedge clk);
    chk("sel_ready", 32'(in_ready), 32'b0100);
    step();
    chk("sel_data", 32'(out_data), 32'hA);
    chk("sel_src", 32'(out_src), 32'd2);
    chk("sel_valid", 32'(out_valid), 32'd1);
    in_valid = 4'b1011;
    step();
    chk("sel_none", 32'(out_valid), 32'd0);

    // Backpressure.
    set_data(1, 2, 3, 4);
    sel = 2'd0;
    in_valid = 4'b1111;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_data", 32'(out_data), 32'd1);
      chk("stall_src", 32'(out_src), 32'd0);
      chk("stall_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    mode = 1'b1;
    in_valid = 4'b1000;
    step();
    chk("refill_valid", 32'(out_valid), 32'd1);
    chk("refill_src", 32'(out_src), 32'd3);

    // Mode switch leaves ptr alone.
    in_valid = 4'b0010;
    step();
    chk("sw_rr1", 32'(out_src), 32'd1);
    mode = 1'b0;
    sel = 2'd3;
    in_valid = 4'b1111;
    step();
    step();
    chk("sw_sel3", 32'(out_src), 32'd3);
    mode = 1'b1;
    step();
    chk("sw_rr2", 32'(out_src), 32'd2);

    // Reset mid-stream.
    out_ready = 1'b0;
    rst = 1'b1;
    step();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    chk("mid_rst_rr0", 32'(out_src), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      in_data   = (N*W)'($urandom);
      in_valid  = N'($urandom);
      mode      = 1'($urandom);
      sel       = SW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
